uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side byte FIFO directly downstream of the UART receiver in the CoreUARTapb datapath.
- Absorbs each received character on the receiver's one-cycle FIFO-write strobe.
- Buffers up to DEPTH characters and presents them first-word-fall-through to the APB register block.
- Maintains level/threshold flags and a sticky overflow flag for the status register and interrupt logic.

Parameters:
DATA_W, 8, character width; 7-bit mode characters arrive with bit 7 = 0 and are stored unchanged
DEPTH, 16, entries; power of two, 2..256
AFULL_LVL, 12, almost_full asserts when level >= AFULL_LVL; range 1..DEPTH

Ports:
clk  input  1  system clock; single clock domain
reset_n  input  1  synchronous active-low reset, sampled on rising clk
wr_en  input  1  one-cycle write strobe from receiver (character complete)
wr_data  input  DATA_W  received character, valid with wr_en
wr_perr  input  1  parity error for this character, valid with wr_en
rd_en  input  1  pop strobe from APB read of the RX data register
rd_data  output  DATA_W  head entry; valid while empty = 0
rd_perr  output  1  parity tag of head entry (see Optional Feature)
empty  output  1  no entries
full  output  1  level == DEPTH
rx_ready  output  1  = ~empty; drives RXRDY status
almost_full  output  1  level >= AFULL_LVL
level  output  log2(DEPTH)+1  current entry count, 0..DEPTH
overflow  output  1  sticky: a write was dropped
clr_overflow  input  1  one-cycle clear from status-register access

Behaviour:
- Reset (reset_n = 0 at clk edge): pointers = 0, level = 0, empty = 1, rx_ready = 0, full = 0, almost_full = 0, overflow = 0, rd_data = 0, rd_perr = 0. Storage contents are not reset.
- Reset mid-operation discards all entries; the next cycle behaves as post-reset.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. level is tracked as a separate counter, or derived from extra-bit pointers; the two are equivalent.
- Write (wr_en = 1, not full, or full with a same-cycle pop):
  - Entry stored at wr_ptr; wr_ptr += 1.
  - Visible on rd_data the next cycle if the FIFO was empty (1-cycle write-to-read latency).
- Read (rd_en = 1, empty = 0):
  - rd_ptr += 1; the next entry appears on rd_data the following cycle.
  - rd_data is the memory output at rd_ptr; a registered-head implementation is acceptable only if the same latency is kept.
- Underflow (rd_en with empty = 1): ignored. No pointer change, no flag.
- Simultaneous wr_en & rd_en:
  - Not empty: push and pop both occur; level unchanged.
  - Full: the pop frees a slot, the write is accepted, no overflow.
  - Empty: only the write takes effect; level becomes 1.
- Overflow: wr_en while full with no pop. The character is dropped, storage and pointers are unchanged, and overflow = 1 from the next cycle.
- overflow clear: held until clr_overflow = 1. If clr_overflow and a new overflow event coincide, set wins.
- Flags are registered or derived from registered level; all update in the same cycle as level.
- No internal state machine beyond pointer/count registers; all actions are qualified only by the strobes (the strobes are already baud-enable qualified upstream).

Optional Feature:
Macro: UART_RX_FIFO_PERR_TAG_EN
- Defined: each entry is DATA_W+1 bits wide, and wr_perr is stored with its character. rd_perr reflects the head entry's tag, with the same latency and pop rules as rd_data.
- Undefined: storage is DATA_W bits, wr_perr is ignored, and rd_perr is tied 0.

Decomposition:
- Package uart_rx_fifo_pkg:
  - default DATA_W/DEPTH constants
  - function clog2 for pointer widths
  - typedef of the entry type (data plus optional perr)
- One sub-module, uart_rx_fifo_mem: simple dual-port register array with one write port and an asynchronous read port addressed by rd_ptr.
- Pointer, level, flag and overflow logic stay in uart_rx_fifo.

Test Plan:
- Reset, then write 0x41 -> next cycle rd_data = 0x41, empty = 0, rx_ready = 1, level = 1. Then rd_en -> next cycle empty = 1, level = 0.
- Write 16 bytes 0x00..0x0F -> almost_full = 1 after the 12th write, full = 1 after the 16th. Then write 0xAA -> overflow = 1, level stays 16. Drain -> reads 0x00..0x0F in order, 0xAA is never seen.
- Full FIFO, same-cycle wr_en(0x55) and rd_en -> no overflow, level stays 16; 0x55 is read last after 15 more pops.
- Empty FIFO: rd_en alone -> no change; simultaneous wr_en(0x33) and rd_en -> level = 1, rd_data = 0x33.
- overflow set, then clr_overflow coinciding with a new dropped write -> overflow stays 1. A clr_overflow alone -> 0. Reset mid-stream with level = 5 -> level = 0 and empty = 1 next cycle.
- With UART_RX_FIFO_PERR_TAG_EN defined: write (0x12, perr = 1) then (0x34, perr = 0) -> rd_perr reads 1 then 0 in step with the data. With the macro undefined -> rd_perr stays 0.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared constants, width helpers and the entry type for the
// UART receive FIFO.
// Optional feature macro: UART_RX_FIFO_PERR_TAG_EN (store the parity tag with each character).
package uart_rx_fifo_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefDepth = 16;

`ifdef UART_RX_FIFO_PERR_TAG_EN
  localparam int unsigned PerrW = 1;

  typedef struct packed {
    logic                perr;
    logic [DefDataW-1:0] data;
  } entry_t;
`else
  localparam int unsigned PerrW = 0;

  typedef struct packed {
    logic [DefDataW-1:0] data;
  } entry_t;
`endif

  // Ceiling log2, valid for 1..2^31.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Stored entry width for a given character width.
  function automatic int unsigned entry_w(input int unsigned data_w);
    return data_w + PerrW;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// uart_rx_fifo_mem: simple dual-port register array for the UART RX FIFO.
// One synchronous write port, one asynchronous read port. Contents are not reset.
// Ports:
//   clk    - system clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational from raddr)
module uart_rx_fifo_mem #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side first-word-fall-through byte FIFO behind the UART receiver.
// Optional feature macro: UART_RX_FIFO_PERR_TAG_EN (parity tag stored per entry, on rd_perr).
// Ports:
//   clk, reset_n   - clock, synchronous active-low reset
//   wr_en/wr_data/wr_perr - character write strobe, character, parity error
//   rd_en          - pop strobe
//   rd_data/rd_perr - head entry (0 while empty)
//   empty/full/rx_ready/almost_full/level - occupancy flags and count
//   overflow/clr_overflow - sticky dropped-write flag and its clear
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned AFULL_LVL = 12
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_perr,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_perr,
  output logic                     empty,
  output logic                     full,
  output logic                     rx_ready,
  output logic                     almost_full,
  output logic [clog2(DEPTH):0]    level,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int unsigned PtrW   = clog2(DEPTH);
  localparam int unsigned LvlW   = PtrW + 1;
  localparam int unsigned EntryW = entry_w(DATA_W);

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              do_wr, do_rd, ovf_evt;
  logic [EntryW-1:0] mem_wdata, mem_rdata;

  assign empty       = (level_q == '0);
  assign full        = (level_q == LvlW'(DEPTH));
  assign rx_ready    = ~empty;
  assign almost_full = (level_q >= LvlW'(AFULL_LVL));
  assign level       = level_q;
  assign overflow    = overflow_q;

  // A pop while full frees the slot the write needs, so the write is still taken.
  assign do_wr   = wr_en & (~full | rd_en);
  assign do_rd   = rd_en & ~empty;
  assign ovf_evt = wr_en & full & ~rd_en;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PtrW'(1);
    level_d = level_q + LvlW'(do_wr) - LvlW'(do_rd);
    // Set wins over a coincident clear.
    if (clr_overflow) overflow_d = 1'b0;
    if (ovf_evt)      overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef UART_RX_FIFO_PERR_TAG_EN
  assign mem_wdata = {wr_perr, wr_data};
  assign rd_perr   = ~empty & mem_rdata[DATA_W];
`else
  logic unused_perr;
  assign unused_perr = wr_perr;
  assign mem_wdata   = wr_data;
  assign rd_perr     = 1'b0;
`endif

  // Storage is never reset, so mask the head while empty.
  assign rd_data = empty ? '0 : mem_rdata[DATA_W-1:0];

  uart_rx_fifo_mem #(
    .WIDTH  (EntryW),
    .DEPTH  (DEPTH),
    .ADDR_W (PtrW)
  ) u_mem (
    .clk   (clk),
    .we    (do_wr),
    .waddr (wr_ptr_q),
    .wdata (mem_wdata),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_PERR_TAG_EN
  localparam bit PerrEn = 1'b1;
`else
  localparam bit PerrEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n, wr_en, wr_perr, rd_en, clr_overflow;
  logic [7:0] wr_data, rd_data;
  logic       rd_perr, empty, full, rx_ready, almost_full, overflow;
  logic [4:0] level;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_W    (8),
    .DEPTH     (16),
    .AFULL_LVL (12)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_perr      (wr_perr),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_perr      (rd_perr),
    .empty        (empty),
    .full         (full),
    .rx_ready     (rx_ready),
    .almost_full  (almost_full),
    .level        (level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_perr = 1'b0; rd_en = 1'b0;
    clr_overflow = 1'b0; wr_data = 8'h00;
    step(); step();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_afull", 32'(almost_full), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_perr", 32'(rd_perr), 32'd0);
    reset_n = 1'b1;
    step();

    // Single write then read.
    push(8'h41);
    check("w1_data", 32'(rd_data), 32'h41);
    check("w1_empty", 32'(empty), 32'd0);
    check("w1_rx_ready", 32'(rx_ready), 32'd1);
    check("w1_level", 32'(level), 32'd1);
    pop();
    check("r1_empty", 32'(empty), 32'd1);
    check("r1_level", 32'(level), 32'd0);

    // Fill to full, watching almost_full / full thresholds.
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      check("fill_level", 32'(level), 32'(i + 1));
      check("fill_afull", 32'(almost_full), 32'((i + 1) >= 12));
      check("fill_full", 32'(full), 32'(i == 15));
    end
    check("pre_ovf", 32'(overflow), 32'd0);
    push(8'hAA);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_level", 32'(level), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("drain_data", 32'(rd_data), 32'(i));
      pop();
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("ovf_sticky", 32'(overflow), 32'd1);
    clr_overflow = 1'b1; step(); clr_overflow = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
    wr_en = 1'b1; wr_data = 8'h55; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    check("fullrw_ovf", 32'(overflow), 32'd0);
    check("fullrw_level", 32'(level), 32'd16);
    for (int i = 1; i < 16; i++) begin
      check("fullrw_data", 32'(rd_data), 32'(8'h80 + i));
      pop();
    end
    check("fullrw_last", 32'(rd_data), 32'h55);
    check("fullrw_lvl1", 32'(level), 32'd1);
    pop();
    check("fullrw_empty", 32'(empty), 32'd1);

    // Underflow, then simultaneous push/pop on empty.
    pop();
    check("uflow_level", 32'(level), 32'd0);
    check("uflow_empty", 32'(empty), 32'd1);
    wr_en = 1'b1; wr_data = 8'h33; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    check("emptyrw_level", 32'(level), 32'd1);
    check("emptyrw_data", 32'(rd_data), 32'h33);
    pop();

    // Overflow set vs. clear collision, then clear alone.
    for (int i = 0; i < 16; i++) push(8'(8'hC0 + i));
    push(8'hEE);
    check("ovf2_set", 32'(overflow), 32'd1);
    wr_en = 1'b1; wr_data = 8'hEF; clr_overflow = 1'b1;
    step();
    wr_en = 1'b0; clr_overflow = 1'b0;
    check("ovf_setwins", 32'(overflow), 32'd1);
    check("ovf_setwins_lvl", 32'(level), 32'd16);
    clr_overflow = 1'b1; step(); clr_overflow = 1'b0;
    check("ovf_clr2", 32'(overflow), 32'd0);

    // Reset mid-stream at level 5.
    for (int i = 0; i < 11; i++) pop();
    check("mid_level", 32'(level), 32'd5);
    check("mid_data", 32'(rd_data), 32'hCB);
    reset_n = 1'b0; step(); reset_n = 1'b1;
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_data", 32'(rd_data), 32'd0);

    // Parity tag travels with its character when the feature is built in.
    wr_perr = 1'b1; push(8'h12);
    wr_perr = 1'b0; push(8'h34);
    check("perr_d0", 32'(rd_data), 32'h12);
    check("perr_t0", 32'(rd_perr), 32'(PerrEn));
    pop();
    check("perr_d1", 32'(rd_data), 32'h34);
    check("perr_t1", 32'(rd_perr), 32'd0);
    pop();
    check("perr_empty", 32'(rd_perr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
